// File: rtl/jk_pkg.sv
// jk_pkg: shared state encoding and command-mode constants for the
// JK excitation generator.
package jk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } jk_state_t;

    localparam logic MODE_JUMP  = 1'b0;
    localparam logic MODE_COUNT = 1'b1;

endpackage

// File: rtl/jk_excite_bit.sv
// jk_excite_bit: per-bit excitation for one JK flip-flop, moving q to e.
// JK_EXCITE_TOGGLE_EN selects toggle drive (J = K = 1 on bits that change);
// otherwise set/reset drive is used and J, K are never both high.
module jk_excite_bit (
    input  logic q,
    input  logic e,
    output logic j,
    output logic k
);

`ifdef JK_EXCITE_TOGGLE_EN
    // Toggle every bit that differs, leave matching bits alone.
    always_comb begin
        j = q ^ e;
        k = q ^ e;
    end
`else
    // Set a bit that must rise, reset a bit that must fall.
    always_comb begin
        j = ~q & e;
        k = q & ~e;
    end
`endif

endmodule

// File: rtl/jk_excite_gen.sv
// jk_excite_gen: drives an external JK register bank to a commanded value,
// either in one jump or by single steps, checking q_fb after every drive
// and retrying a bounded number of times before flagging err.
// Optional macro: JK_EXCITE_TOGGLE_EN (toggle-style excitation).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a command; err holds its last value
// ST_DRIVE | J/K applied to the bank for exactly one cycle
// ST_CHECK | compare q_fb with the expected value, retry/step/finish
// ST_DONE  | one-cycle done pulse
module jk_excite_gen
    import jk_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_mode,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    jk_state_t        state, state_n;
    logic [WIDTH-1:0] target_r, target_n;
    logic             mode_r, mode_n;
    logic [WIDTH-1:0] e_r, e_n;
    logic [RW-1:0]    retry_r, retry_n;
    logic             err_n;
    logic             drive_n;
    logic [WIDTH-1:0] jd, kd;

    // One step from cur toward tgt; never steps past tgt, so never wraps.
    function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                     input logic [WIDTH-1:0] tgt);
        return (tgt > cur) ? cur + WIDTH'(1) : cur - WIDTH'(1);
    endfunction

    // Excitation is computed a cycle ahead from the next expected value; the
    // bank is idle then, so q_fb is the value it will hold during DRIVE.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_excite_bit u_bit (
            .q (q_fb[i]),
            .e (e_n[i]),
            .j (jd[i]),
            .k (kd[i])
        );
    end

    // State register plus latched command, expected value, retries and J/K.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state    <= ST_IDLE;
            target_r <= '0;
            mode_r   <= MODE_JUMP;
            e_r      <= '0;
            retry_r  <= '0;
            err      <= 1'b0;
            J        <= '0;
            K        <= '0;
        end else begin
            state    <= state_n;
            target_r <= target_n;
            mode_r   <= mode_n;
            e_r      <= e_n;
            retry_r  <= retry_n;
            err      <= err_n;
            J        <= drive_n ? jd : '0;
            K        <= drive_n ? kd : '0;
        end
    end

    // Next-state logic, expected-value selection and retry bookkeeping.
    always_comb begin
        state_n  = state;
        target_n = target_r;
        mode_n   = mode_r;
        e_n      = e_r;
        retry_n  = retry_r;
        err_n    = err;
        drive_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    target_n = cmd_target;
                    mode_n   = cmd_mode;
                    retry_n  = '0;
                    err_n    = 1'b0;
                    if (q_fb == cmd_target) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_DRIVE;
                        drive_n = 1'b1;
                        e_n     = (cmd_mode == MODE_JUMP) ? cmd_target
                                                          : step_toward(q_fb, cmd_target);
                    end
                end
            end
            ST_DRIVE: state_n = ST_CHECK;
            ST_CHECK: begin
                if (q_fb != e_r) begin
                    if (retry_r < RW'(MAX_RETRY)) begin
                        retry_n = retry_r + 1'b1;
                        state_n = ST_DRIVE;
                        drive_n = 1'b1;
                    end else begin
                        err_n   = 1'b1;
                        state_n = ST_IDLE;
                    end
                end else if (mode_r == MODE_JUMP || e_r == target_r) begin
                    state_n = ST_DONE;
                end else begin
                    retry_n = '0;
                    e_n     = step_toward(q_fb, target_r);
                    state_n = ST_DRIVE;
                    drive_n = 1'b1;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_jk_excite_gen.sv
// tb_jk_excite_gen: directed bench with a behavioural 4-bit JK bank fed by
// the DUT's J/K and feeding q_fb back. All sampling and driving happens on
// the falling edge.
module tb_jk_excite_gen;
    import jk_pkg::*;

`ifdef JK_EXCITE_TOGGLE_EN
    localparam bit TOG = 1'b1;
`else
    localparam bit TOG = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_mode;
    logic [3:0] cmd_target;
    logic [3:0] q_bank;
    logic [3:0] J, K;
    logic       busy, done, err;

    logic       load_en;
    logic [3:0] load_val;
    logic       stuck;

    int n_checks = 0;
    int n_err    = 0;
    int drives   = 0;

    always #5 CLK = ~CLK;

    jk_excite_gen #(.WIDTH(4), .MAX_RETRY(2)) dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_target (cmd_target),
        .q_fb       (q_bank),
        .J          (J),
        .K          (K),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // JK bank: Q+ = J & ~Q | ~K & Q, with bench-side load and stuck-at-0.
    always @(posedge CLK) begin
        if (load_en)    q_bank <= load_val;
        else if (stuck) q_bank <= 4'b0000;
        else            q_bank <= (J & ~q_bank) | (~K & q_bank);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, counting cycles in which J/K drive.
    task automatic step();
        @(negedge CLK);
        if ((J | K) != 4'b0000) drives++;
    endtask

    initial begin
        RST_n = 1'b0; cmd_valid = 1'b0; cmd_mode = MODE_JUMP; cmd_target = 4'h0;
        load_en = 1'b1; load_val = 4'b0101; stuck = 1'b0;
        step(); step();
        chk("rst_ready", cmd_ready, 1); chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);       chk("rst_err", err, 0);
        chk("rst_j", J, 0);             chk("rst_k", K, 0);
        RST_n = 1'b1; load_en = 1'b0;
        step();
        chk("idle_q", q_bank, 4'b0101);

        // JUMP 0101 -> 1100
        drives = 0;
        cmd_valid = 1'b1; cmd_mode = MODE_JUMP; cmd_target = 4'b1100;
        step();
        cmd_valid = 1'b0;
        chk("jump_busy", busy, 1); chk("jump_ready", cmd_ready, 0);
        chk("jump_j", J, TOG ? 4'b1001 : 4'b1000);
        chk("jump_k", K, TOG ? 4'b1001 : 4'b0001);
        step();
        chk("jump_chk_j", J, 0); chk("jump_chk_k", K, 0);
        chk("jump_chk_q", q_bank, 4'b1100); chk("jump_chk_done", done, 0);
        step();
        chk("jump_done", done, 1); chk("jump_done_busy", busy, 1);
        step();
        chk("jump_after_done", done, 0); chk("jump_after_busy", busy, 0);
        chk("jump_err", err, 0); chk("jump_drives", drives, 1);
        chk("jump_final_q", q_bank, 4'b1100);

        // COUNT 3 -> 6
        load_en = 1'b1; load_val = 4'd3;
        step();
        load_en = 1'b0; drives = 0;
        cmd_valid = 1'b1; cmd_mode = MODE_COUNT; cmd_target = 4'd6;
        step();
        cmd_valid = 1'b0;
        chk("cnt_j1", J, TOG ? 4'b0111 : 4'b0100);
        chk("cnt_k1", K, TOG ? 4'b0111 : 4'b0011);
        step(); chk("cnt_q4", q_bank, 4'd4); chk("cnt_done_a", done, 0);
        step(); chk("cnt_j2", J, 4'b0001); chk("cnt_k2", K, TOG ? 4'b0001 : 4'b0000);
        step(); chk("cnt_q5", q_bank, 4'd5); chk("cnt_done_b", done, 0);
        step(); chk("cnt_j3", J, TOG ? 4'b0011 : 4'b0010);
        chk("cnt_k3", K, TOG ? 4'b0011 : 4'b0001);
        step(); chk("cnt_q6", q_bank, 4'd6); chk("cnt_done_c", done, 0);
        step(); chk("cnt_done", done, 1);
        step(); chk("cnt_after_done", done, 0); chk("cnt_busy", busy, 0);
        chk("cnt_drives", drives, 3); chk("cnt_final_q", q_bank, 4'd6);

        // Stuck-at-0 bank, JUMP to 0001: three drives then err
        load_en = 1'b1; load_val = 4'd0; stuck = 1'b1;
        step();
        load_en = 1'b0; drives = 0;
        cmd_valid = 1'b1; cmd_mode = MODE_JUMP; cmd_target = 4'b0001;
        step();
        cmd_valid = 1'b0;
        chk("stk_j1", J, 4'b0001);
        step(); chk("stk_chk1_j", J, 0); chk("stk_err_a", err, 0);
        step(); chk("stk_j2", J, 4'b0001);
        step(); chk("stk_err_b", err, 0);
        step(); chk("stk_j3", J, 4'b0001);
        step(); chk("stk_err_c", err, 0); chk("stk_busy_c", busy, 1);
        step(); chk("stk_err", err, 1); chk("stk_busy", busy, 0);
        chk("stk_done", done, 0);
        step(); step();
        chk("stk_err_held", err, 1); chk("stk_drives", drives, 3);

        // Next accept (q already equals target) clears err, done with no drive
        drives = 0;
        cmd_valid = 1'b1; cmd_mode = MODE_JUMP; cmd_target = 4'b0000;
        step();
        cmd_valid = 1'b0;
        chk("clr_err", err, 0); chk("clr_done", done, 1); chk("clr_j", J, 0);
        step(); chk("clr_after_done", done, 0); chk("clr_drives", drives, 0);
        stuck = 1'b0;

        // Reset during a COUNT drive: 0 -> 5
        cmd_valid = 1'b1; cmd_mode = MODE_COUNT; cmd_target = 4'd5;
        step();
        cmd_valid = 1'b0;
        chk("mid_j", J, 4'b0001);
        RST_n = 1'b0;
        step();
        chk("mid_rst_j", J, 0); chk("mid_rst_k", K, 0);
        chk("mid_rst_ready", cmd_ready, 1); chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0); chk("mid_rst_err", err, 0);
        RST_n = 1'b1;
        step(); chk("mid_idle_done", done, 0); chk("mid_q", q_bank, 4'd1);

        // Command with q == target: straight to done, no drive cycle
        drives = 0;
        cmd_valid = 1'b1; cmd_mode = MODE_COUNT; cmd_target = 4'd1;
        step();
        cmd_valid = 1'b0;
        chk("eq_done", done, 1); chk("eq_j", J, 0); chk("eq_k", K, 0);
        step(); chk("eq_after_done", done, 0); chk("eq_ready", cmd_ready, 1);
        chk("eq_drives", drives, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
